// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the 640x480@60 display path.
// Holds the default horizontal/vertical timing, derived totals and sync windows,
// the RGB332 field positions and the blanking colour.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV_DEF        = 4;
  localparam int unsigned COLOUR_LATENCY_DEF = 1;
  localparam bit          SYNC_ACTIVE_DEF    = 1'b0;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  // RGB332 layout: {R[2:0], G[2:0], B[1:0]}
  localparam int unsigned RGB_R_HI = 7;
  localparam int unsigned RGB_R_LO = 5;
  localparam int unsigned RGB_G_HI = 4;
  localparam int unsigned RGB_G_LO = 2;
  localparam int unsigned RGB_B_HI = 1;
  localparam int unsigned RGB_B_LO = 0;

  localparam logic [7:0] COLOUR_BLANK = 8'h00;

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider.
// Counts 0..CLK_DIV-1 and flags the last count of each pixel period.
//   clk_i    : system clock
//   reset_i  : synchronous, active-high reset (divider back to 0)
//   tick_o   : pixel tick, high when the divider is at CLK_DIV-1
//   sample_o : colour sample strobe, coincident with the tick
module vga_pixel_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o,
  output logic sample_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            at_max;

  always_comb begin
    at_max = (div_q == DivMax);
    div_d  = at_max ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o   = at_max;
  // Sampling on the last divider count gives the renderer CLK_DIV-1 cycles
  // after the address change, which covers COLOUR_LATENCY.
  assign sample_o = at_max;

endmodule

// File: rtl/vga_display_driver.sv
// VGA raster generator and pixel sink.
// Walks the raster, publishes the current pixel address, samples the colour the
// renderer returns and drives registered RGB332, HS and VS one pixel period later.
//   CLK        : system clock
//   RESET      : synchronous, active-high
//   ADDRH/V    : current pixel address (0 during blanking)
//   COLOUR_IN  : renderer colour for ADDRH/ADDRV
//   COLOUR_OUT : registered RGB332, forced to blank when not visible
//   HS/VS      : syncs, delayed to stay aligned with COLOUR_OUT
//   VISIBLE    : COLOUR_OUT carries a visible pixel
//   FRAME_TICK : one-CLK pulse when pixel (0,0) is addressed
module vga_display_driver #(
  parameter int unsigned CLK_DIV        = vga_timing_pkg::CLK_DIV_DEF,
  parameter int unsigned COLOUR_LATENCY = vga_timing_pkg::COLOUR_LATENCY_DEF,
  parameter int unsigned H_VISIBLE      = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT        = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC         = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK         = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE      = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT        = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC         = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK         = vga_timing_pkg::V_BACK,
  parameter bit          SYNC_ACTIVE    = vga_timing_pkg::SYNC_ACTIVE_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [9:0] ADDRH,
  output logic [8:0] ADDRV,
  input  logic [7:0] COLOUR_IN,
  output logic [7:0] COLOUR_OUT,
  output logic       HS,
  output logic       VS,
  output logic       VISIBLE,
  output logic       FRAME_TICK
);

  import vga_timing_pkg::*;

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast   = 10'(HTotal - 1);
  localparam logic [9:0] VLast   = 10'(VTotal - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [9:0] HsFirst = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HsLast  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VsLast  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if (COLOUR_LATENCY >= CLK_DIV) begin : gen_latency_check
    $error("COLOUR_LATENCY must be less than CLK_DIV");
  end

  logic tick, sample;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk_i    (CLK),
    .reset_i  (RESET),
    .tick_o   (tick),
    .sample_o (sample)
  );

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] addrh_q, addrh_d;
  logic [8:0] addrv_q, addrv_d;
  // Flags of the pixel currently on the address bus.
  logic       pix_vis_q, pix_vis_d, pix_hs_q, pix_hs_d, pix_vs_q, pix_vs_d;
  logic [7:0] colour_hold_q, colour_hold_d;
  logic [7:0] colour_out_q, colour_out_d;
  logic       hs_q, hs_d, vs_q, vs_d, visible_q, visible_d, frame_tick_q, frame_tick_d;
  logic       in_vis, hs_act, vs_act;

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    addrh_d       = addrh_q;
    addrv_d       = addrv_q;
    pix_vis_d     = pix_vis_q;
    pix_hs_d      = pix_hs_q;
    pix_vs_d      = pix_vs_q;
    colour_hold_d = colour_hold_q;
    colour_out_d  = colour_out_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    visible_d     = visible_q;

    in_vis = (h_q < HVis) && (v_q < VVis);
    hs_act = (h_q >= HsFirst) && (h_q <= HsLast);
    vs_act = (v_q >= VsFirst) && (v_q <= VsLast);

    if (sample) begin
      colour_hold_d = COLOUR_IN;
    end

    frame_tick_d = tick && (h_q == '0) && (v_q == '0);

    if (tick) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end

      addrh_d   = in_vis ? h_q : '0;
      addrv_d   = in_vis ? v_q[8:0] : '0;
      pix_vis_d = in_vis;
      pix_hs_d  = hs_act;
      pix_vs_d  = vs_act;

      // Output stage shows the pixel whose address was published last period;
      // its colour is the value being sampled on this same edge.
      colour_out_d = pix_vis_q ? colour_hold_d : COLOUR_BLANK;
      hs_d         = pix_hs_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_d         = pix_vs_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      visible_d    = pix_vis_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_q           <= '0;
      v_q           <= '0;
      addrh_q       <= '0;
      addrv_q       <= '0;
      pix_vis_q     <= 1'b0;
      pix_hs_q      <= 1'b0;
      pix_vs_q      <= 1'b0;
      colour_hold_q <= COLOUR_BLANK;
      colour_out_q  <= COLOUR_BLANK;
      hs_q          <= ~SYNC_ACTIVE;
      vs_q          <= ~SYNC_ACTIVE;
      visible_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      addrh_q       <= addrh_d;
      addrv_q       <= addrv_d;
      pix_vis_q     <= pix_vis_d;
      pix_hs_q      <= pix_hs_d;
      pix_vs_q      <= pix_vs_d;
      colour_hold_q <= colour_hold_d;
      colour_out_q  <= colour_out_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      visible_q     <= visible_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign ADDRH      = addrh_q;
  assign ADDRV      = addrv_q;
  assign COLOUR_OUT = colour_out_q;
  assign HS         = hs_q;
  assign VS         = vs_q;
  assign VISIBLE    = visible_q;
  assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_vga_display_driver.sv
// Bench for vga_display_driver using a shrunken raster so several frames fit.
// Expected outputs come from pixel-index arithmetic after the last reset edge.
module tb_vga_display_driver;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned H_VIS = 16, H_FP = 2, H_SW = 3, H_BP = 3;
  localparam int unsigned V_VIS = 6, V_FP = 1, V_SW = 2, V_BP = 2;
  localparam int unsigned H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned FRAME_PIX  = H_TOT * V_TOT;
  localparam int unsigned FRAME_CLKS = FRAME_PIX * CLK_DIV;
  localparam int unsigned HS_FIRST = H_VIS + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SW - 1;
  localparam int unsigned VS_FIRST = V_VIS + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SW - 1;

  typedef struct packed {
    logic [9:0] ah;
    logic [8:0] av;
    logic [7:0] col;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       ft;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] colour_in = 8'h00;
  logic [9:0] addrh;
  logic [8:0] addrv;
  logic [7:0] colour_out;
  logic       hs, vs, visible, frame_tick;

  vga_display_driver #(
    .CLK_DIV        (CLK_DIV),
    .COLOUR_LATENCY (1),
    .H_VISIBLE      (H_VIS),
    .H_FRONT        (H_FP),
    .H_SYNC         (H_SW),
    .H_BACK         (H_BP),
    .V_VISIBLE      (V_VIS),
    .V_FRONT        (V_FP),
    .V_SYNC         (V_SW),
    .V_BACK         (V_BP),
    .SYNC_ACTIVE    (1'b0)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    .ADDRH      (addrh),
    .ADDRV      (addrv),
    .COLOUR_IN  (colour_in),
    .COLOUR_OUT (colour_out),
    .HS         (hs),
    .VS         (vs),
    .VISIBLE    (visible),
    .FRAME_TICK (frame_tick)
  );

  always #5 clk = ~clk;

  logic [7:0]  lut [V_VIS][H_VIS];
  bit          ff_mode = 1'b0;
  bit          done = 1'b0;
  bit          target_miss = 1'b0;
  int unsigned n_clk = 0;
  int          n_checks = 0, n_pass = 0;
  int          ft_exp = 0, ft_seen = 0;
  obs_t        sb_q[$];
  logic [18:0] last_addr = '1;

  function automatic logic [7:0] lut_at(input logic [9:0] x, input logic [8:0] y);
    if (x < H_VIS && y < V_VIS) return lut[y][x];
    return 8'h00;
  endfunction

  // Expected outputs n clocks after the last reset edge. Pixel tick j lands at
  // n = j*CLK_DIV; it publishes the address of pixel j-1 and shows pixel j-2.
  function automatic obs_t model(input int unsigned n, input bit ff);
    int unsigned k, p, h, v;
    obs_t e;
    e = '{ah: '0, av: '0, col: 8'h00, hs: 1'b1, vs: 1'b1, vis: 1'b0, ft: 1'b0};
    k = n / CLK_DIV;
    if (k >= 1) begin
      p = k - 1;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      if (h < H_VIS && v < V_VIS) begin
        e.ah = 10'(h);
        e.av = 9'(v);
      end
      e.ft = (n % CLK_DIV == 0) && (p % FRAME_PIX == 0);
    end
    if (k >= 2) begin
      p = k - 2;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      e.vis = (h < H_VIS) && (v < V_VIS);
      if (e.vis) e.col = ff ? 8'hFF : lut[v][h];
      e.hs = !(h >= HS_FIRST && h <= HS_LAST);
      e.vs = !(v >= VS_FIRST && v <= VS_LAST);
    end
    return e;
  endfunction

  task automatic step(input logic rst);
    obs_t e;
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    if (reset) n_clk = 0;
    else n_clk++;
    e = model(n_clk, ff_mode);
    sb_q.push_back(e);
    ft_exp += int'(e.ft);
  endtask

  function automatic bit at_reset_target(input int unsigned n);
    int unsigned k, p;
    k = n / CLK_DIV;
    if (k < 1) return 1'b0;
    p = k - 1;
    return ((p % H_TOT) == HS_FIRST + 1) && (((p / H_TOT) % V_TOT) == 3);
  endfunction

  // Renderer: one CLK of garbage after each address change, then the table value.
  always @(posedge clk) begin : renderer
    logic [18:0] cur;
    #1;
    cur = {addrh, addrv};
    if (ff_mode) colour_in = 8'hFF;
    else if (cur !== last_addr) colour_in = lut_at(addrh, addrv) ^ 8'($urandom_range(1, 255));
    else colour_in = lut_at(addrh, addrv);
    last_addr = cur;
  end

  always @(negedge clk) begin : monitor
    obs_t e, got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = '{ah: addrh, av: addrv, col: colour_out, hs: hs, vs: vs, vis: visible,
              ft: frame_tick};
      n_checks++;
      if (got === e) n_pass++;
      else $display("FAIL pixel_out t=%0t got ah=%0d av=%0d col=%02h hs=%b vs=%b vis=%b ft=%b exp ah=%0d av=%0d col=%02h hs=%b vs=%b vis=%b ft=%b",
                    $time, got.ah, got.av, got.col, got.hs, got.vs, got.vis, got.ft,
                    e.ah, e.av, e.col, e.hs, e.vs, e.vis, e.ft);
      if (frame_tick === 1'b1) ft_seen++;
    end else if (done) begin
      n_checks++;
      if (!target_miss) n_pass++;
      else $display("FAIL reset_target got not_reached exp reached");
      n_checks++;
      if (ft_seen == ft_exp) n_pass++;
      else $display("FAIL frame_tick_count got %0d exp %0d", ft_seen, ft_exp);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    int guard;
    for (int y = 0; y < V_VIS; y++)
      for (int x = 0; x < H_VIS; x++)
        lut[y][x] = 8'($urandom);

    repeat (3) step(1'b1);
    for (int i = 0; i < 2 * FRAME_CLKS; i++) step(1'b0);

    // Reset mid-frame while HS is active on the output.
    guard = 0;
    while (!at_reset_target(n_clk) && guard < FRAME_CLKS) begin
      step(1'b0);
      guard++;
    end
    if (guard >= FRAME_CLKS) target_miss = 1'b1;
    ff_mode = 1'b1;
    step(1'b1);
    for (int i = 0; i < FRAME_CLKS + 200; i++) step(1'b0);

    ff_mode = 1'b0;
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 1200; i++) step(1'b0);
    done = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
